pipelined_addsub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor that extends the team's 8-bit ripple adder: generic width, configurable number of carry-pipeline stages, add/subtract mode, carry-in, and valid/ready handshakes on both sides. It sits between the operand registers and the result bus of the ALU datapath. It accepts one operation per cycle and produces flags alongside the result.

---
 rtl/alu_pkg.sv | 14 +
 rtl/addsub_chunk.sv | 18 +
 rtl/pipelined_addsub.sv | 124 ++++++++++++
 tb/tb_pipelined_addsub.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the result-flag bundle
// used by the add/subtract pipeline and later ALU blocks.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic c_out;
    logic overflow;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CW-bit slice of the adder: sum, carry-out and the carry
// into the slice MSB, which the top-level overflow flag needs.
module addsub_chunk #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic          c_i,
  output logic [CW-1:0] s_o,
  output logic          c_o,
  output logic          c_msb_o
);

  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, c_i};
  // Recover the carry into the MSB from the MSB sum bit and its operands.
  assign c_msb_o = s_o[CW-1] ^ a_i[CW-1] ^ b_i[CW-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Carry-pipelined two's-complement adder/subtractor with valid/ready on
// both sides; stage k adds chunk k, upper operands skew forward with it.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  alu_flags_t       flags_q;

  // Single global advance: the whole pipe moves or the whole pipe holds.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  assign b_eff   = (sub == OP_SUB) ? ~b : b;
  assign cin_eff = (sub == OP_SUB) ? ~c_in : c_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * CW;

    logic [WIDTH-LO-1:0] a_in;
    logic [WIDTH-LO-1:0] b_in;
    logic                cin_in;
    logic                v_in;
    logic [LO+CW-1:0]    s_d;
    logic [CW-1:0]       ch_s;
    logic                ch_c;
    logic                ch_cm;

    if (k == 0) begin : g_first
      assign a_in   = a;
      assign b_in   = b_eff;
      assign cin_in = cin_eff;
      assign v_in   = in_valid;
      assign s_d    = ch_s;
    end else begin : g_next
      assign a_in   = g_st[k-1].g_mid.a_q;
      assign b_in   = g_st[k-1].g_mid.b_q;
      assign cin_in = g_st[k-1].g_mid.c_q;
      assign v_in   = g_st[k-1].g_mid.v_q;
      assign s_d    = {ch_s, g_st[k-1].g_mid.s_q};
    end

    addsub_chunk #(.CW(CW)) u_chunk (
      .a_i     (a_in[CW-1:0]),
      .b_i     (b_in[CW-1:0]),
      .c_i     (cin_in),
      .s_o     (ch_s),
      .c_o     (ch_c),
      .c_msb_o (ch_cm)
    );

    if (k < STAGES-1) begin : g_mid
      logic                   v_q;
      logic                   c_q;
      logic [LO+CW-1:0]       s_q;
      logic [WIDTH-LO-CW-1:0] a_q;
      logic [WIDTH-LO-CW-1:0] b_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset)    v_q <= 1'b0;
        else if (adv) v_q <= v_in;
      end

      // Datapath registers carry no reset; their valid bit qualifies them.
      always_ff @(posedge clk) begin
        if (adv) begin
          c_q <= ch_c;
          s_q <= s_d;
          a_q <= a_in[WIDTH-LO-1:CW];
          b_q <= b_in[WIDTH-LO-1:CW];
        end
      end
    end else begin : g_last
      alu_flags_t flags_d;

      assign flags_d.c_out    = ch_c;
      assign flags_d.overflow = ch_c ^ ch_cm;
      assign flags_d.zero     = (s_d == '0);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          out_valid_q <= 1'b0;
          sum_q       <= '0;
          flags_q     <= '0;
        end else if (adv) begin
          out_valid_q <= v_in;
          sum_q       <= s_d;
          flags_q     <= flags_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = flags_q.c_out;
  assign overflow  = flags_q.overflow;
  assign zero      = flags_q.zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: 8-bit/2-stage and 16-bit/4-stage
// instances, expectations queued at acceptance and popped by monitors.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       v8 = 0, s8 = 0, c8 = 0, or8 = 1;
  logic [7:0] a8 = 0, b8 = 0;
  logic       rdy8, ov8, co8, of8, z8;
  logic [7:0] sum8;

  logic        v16 = 0, s16 = 0, c16 = 0, or16 = 1;
  logic [15:0] a16 = 0, b16 = 0;
  logic        rdy16, ov16, co16, of16, z16;
  logic [15:0] sum16;

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) dut8 (
    .clk(clk), .reset(rst), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8),
    .sub(s8), .c_in(c8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
    .c_out(co8), .overflow(of8), .zero(z8)
  );

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut16 (
    .clk(clk), .reset(rst), .in_valid(v16), .in_ready(rdy16), .a(a16), .b(b16),
    .sub(s16), .c_in(c16), .out_valid(ov16), .out_ready(or16), .sum(sum16),
    .c_out(co16), .overflow(of16), .zero(z16)
  );

  // Expected entry: {sum[15:0], c_out, overflow, zero}
  logic [18:0] q8[$];
  logic [18:0] q16[$];
  int cnt8 = 0, cnt16 = 0;

  logic [15:0] bpa[3];
  logic [15:0] bpb[3];
  logic        bps[3];
  logic [18:0] bpe[3];

  always @(negedge clk) begin
    if (!rst && ov8 && or8) begin
      logic [18:0] got, e;
      got = {8'h00, sum8, co8, of8, z8};
      checks++;
      cnt8++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL out8_unexpected got %h required none", got);
      end else begin
        e = q8.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL out8_result got %h required %h", got, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov16 && or16) begin
      logic [18:0] got, e;
      got = {sum16, co16, of16, z16};
      checks++;
      cnt16++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL out16_unexpected got %h required none", got);
      end else begin
        e = q16.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL out16_result got %h required %h", got, e);
        end
      end
    end
  end

  function automatic logic [18:0] ex(input logic [15:0] s, input logic co, ov, z);
    return {s, co, ov, z};
  endfunction

  function automatic logic [18:0] model8(input logic [7:0] x, y, input logic sb, ci);
    logic [7:0] be;
    logic       cc;
    logic [8:0] r;
    logic       ovf;
    be  = sb ? ~y : y;
    cc  = sb ? ~ci : ci;
    r   = {1'b0, x} + {1'b0, be} + {8'h00, cc};
    ovf = (x[7] == be[7]) && (r[7] != x[7]);
    return {8'h00, r[7:0], r[8], ovf, (r[7:0] == 8'h00)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", nm, got, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int sel, input logic [15:0] ta, tb, input logic ts, tc,
                      input logic [18:0] e);
    bit ok;
    ok = 0;
    if (sel == 8) begin a8 = ta[7:0]; b8 = tb[7:0]; s8 = ts; c8 = tc; v8 = 1; end
    else          begin a16 = ta; b16 = tb; s16 = ts; c16 = tc; v16 = 1; end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if ((sel == 8) ? rdy8 : rdy16) begin
        ok = 1;
        if (sel == 8) q8.push_back(e);
        else          q16.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (sel == 8) v8 = 0;
    else          v16 = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout got no in_ready required in_ready within 50 cycles");
    end
  endtask

  task automatic backpressure(input int sel);
    int c0;
    c0 = (sel == 8) ? cnt8 : cnt16;
    if (sel == 8) or8 = 0;
    else          or16 = 0;
    fork
      for (int i = 0; i < 3; i++) send(sel, bpa[i], bpb[i], bps[i], 1'b0, bpe[i]);
      begin
        repeat (6) @(negedge clk);
        for (int j = 0; j < 3; j++) begin
          chk("bp_in_ready", (sel == 8) ? rdy8 : rdy16, 0);
          chk("bp_out_valid", (sel == 8) ? ov8 : ov16, 1);
          chk("bp_hold_sum", (sel == 8) ? {8'h00, sum8} : sum16, bpe[0][18:3]);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        if (sel == 8) or8 = 1;
        else          or16 = 1;
      end
    join
    repeat (10) step();
    chk("bp_count", ((sel == 8) ? cnt8 : cnt16) - c0, 3);
    chk("bp_queue_empty", (sel == 8) ? q8.size() : q16.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n0;
    logic [7:0] x, y;
    logic sb, ci;

    // Reset and idle
    repeat (2) @(negedge clk);
    chk("rst_out_valid8", ov8, 0);
    chk("rst_sum8", sum8, 0);
    chk("rst_flags8", {co8, of8, z8}, 0);
    chk("rst_out_valid16", ov16, 0);
    chk("rst_sum16", sum16, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("idle_in_ready8", rdy8, 1);
    chk("idle_out_valid8", ov8, 0);
    step();

    // Directed vectors, first one with a latency check
    send(8, 16'h00FF, 16'h0001, 0, 0, ex(16'h0000, 1, 0, 1));
    @(negedge clk);
    chk("latency_early", ov8, 0);
    @(negedge clk);
    chk("latency_due", ov8, 1);
    step();
    send(8, 16'h007F, 16'h0001, 0, 0, ex(16'h0080, 0, 1, 0));
    send(8, 16'h000F, 16'h0000, 0, 1, ex(16'h0010, 0, 0, 0));
    send(8, 16'h0005, 16'h0007, 1, 0, ex(16'h00FE, 0, 0, 0));
    send(8, 16'h0080, 16'h0001, 1, 0, ex(16'h007F, 1, 1, 0));
    repeat (4) step();
    chk("directed_count", cnt8, 5);
    chk("directed_queue_empty", q8.size(), 0);

    // Back-to-back stream
    t0 = cyc;
    n0 = cnt8;
    for (int i = 0; i < 20; i++) begin
      x  = 8'($urandom_range(0, 255));
      y  = 8'($urandom_range(0, 255));
      sb = 1'($urandom_range(0, 1));
      ci = 1'($urandom_range(0, 1));
      send(8, {8'h00, x}, {8'h00, y}, sb, ci, model8(x, y, sb, ci));
    end
    chk("stream_accept_cycles", cyc - t0, 20);
    repeat (4) step();
    chk("stream_count", cnt8 - n0, 20);
    chk("stream_queue_empty", q8.size(), 0);

    // Backpressure, 8-bit / 2-stage
    bpa[0] = 16'h0012; bpb[0] = 16'h0034; bps[0] = 0; bpe[0] = ex(16'h0046, 0, 0, 0);
    bpa[1] = 16'h0050; bpb[1] = 16'h0050; bps[1] = 0; bpe[1] = ex(16'h00A0, 0, 1, 0);
    bpa[2] = 16'h0000; bpb[2] = 16'h0001; bps[2] = 1; bpe[2] = ex(16'h00FF, 0, 0, 0);
    backpressure(8);

    // Backpressure, 16-bit / 4-stage
    bpa[0] = 16'h00FF; bpb[0] = 16'h0001; bps[0] = 0; bpe[0] = ex(16'h0100, 0, 0, 0);
    bpa[1] = 16'hFFFF; bpb[1] = 16'h0001; bps[1] = 0; bpe[1] = ex(16'h0000, 1, 0, 1);
    bpa[2] = 16'h8000; bpb[2] = 16'h0001; bps[2] = 1; bpe[2] = ex(16'h7FFF, 1, 1, 0);
    backpressure(16);

    // Reset with two items in flight
    n0 = cnt8;
    send(8, 16'h0001, 16'h0001, 0, 0, ex(16'h0002, 0, 0, 0));
    send(8, 16'h0002, 16'h0002, 0, 0, ex(16'h0004, 0, 0, 0));
    rst = 1;
    #1;
    chk("midrst_out_valid", ov8, 0);
    q8.delete();
    repeat (2) step();
    rst = 0;
    repeat (6) step();
    chk("midrst_nothing_out", cnt8 - n0, 0);
    chk("midrst_out_valid_after", ov8, 0);
    chk("midrst_in_ready", rdy8, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
